division_seq: RTL and testbench
===============================

# division_seq

Sequential restoring divider: an 8-bit unsigned dividend divided by a 4-bit unsigned divisor, producing the quotient and the remainder. It is the inverse of the team's 4-bit × 4-bit combinational multiplier, so the product of that multiplier can be fed straight back in. It resolves one quotient bit per clock behind a start/busy/done handshake. It sits in the arithmetic-circuits library next to the multiplier.

## Interface
Parameters:
- DW, default 8: dividend and quotient width.
- VW, default 4: divisor and remainder width. Requires VW ≤ DW.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: request a division; sampled only in IDLE or DONE.
- dividend, input, DW: dividend; captured on the accepting edge.
- divisor, input, VW: divisor; captured on the accepting edge.
- quotient, output, DW: registered quotient.
- remainder, output, VW: registered remainder.
- busy, output, 1: high while in CALC.
- done, output, 1: one-cycle pulse; results are valid from this cycle on.
- div_by_zero, output, 1: error flag for the current result.

## Operation
- There are three states: IDLE, CALC and DONE.
- **IDLE**
  - start=1 with divisor≠0 → CALC.
  - The accepting edge latches dividend into a shift register, latches divisor, clears the partial remainder (VW+1 bits), clears div_by_zero and loads the step counter with DW.
- **Divide by zero**
  - start=1 with divisor=0 → DONE directly.
  - Results: quotient=all ones (8'hFF), remainder=0, div_by_zero=1.
- **CALC**, once per cycle:
  - partial = {partial[VW-1:0], next dividend MSB}.
  - If partial ≥ divisor: partial -= divisor and shift in quotient bit 1.
  - Otherwise shift in quotient bit 0.
  - The counter decrements; at zero → DONE, and quotient/remainder load from the working registers.
- **DONE**
  - done=1 for exactly this cycle.
  - start=1 → accepted with the same rules as IDLE (back-to-back operation).
  - Otherwise → IDLE.
- quotient, remainder and div_by_zero hold their values until the next accepted start's result is loaded. They are not cleared by IDLE.
- start in CALC is ignored. Input changes in CALC have no effect.
- Width rules:
  - Everything is unsigned.
  - The remainder is always < divisor, so it fits in VW bits.
  - The partial remainder needs VW+1 bits so the comparison cannot overflow.
- Reset, asynchronous, at any time including mid-CALC:
  - State → IDLE.
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
  - The working registers are cleared.
  - No partial result is ever presented.

## Timing
- Accepting edge at cycle 0: busy=1 during cycles 1..DW.
- done=1 during cycle DW+1, with results valid in that cycle. Latency is therefore DW+1 cycles (9 with defaults).
- Divide by zero: done=1 in cycle 1 and busy never rises.
- Back-to-back: start asserted during DONE starts the next CALC in the following cycle. Throughput is one result per DW+1 cycles.
- busy and done are never high together.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- division_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - default widths DIV_DW=8 and DIV_VW=4;
  - the counter width, $clog2(DW+1).
- One sub-module is natural: **division_step**, a combinational single restoring step.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - The top level holds the FSM, the counter and the registers.

## Test plan
- 143 / 12 (the multiplier's 11×12=132 plus 11) → quotient=11, remainder=11, done in cycle 9, busy high in cycles 1–8.
- 255 / 1 → quotient=255, remainder=0. Then 7 / 9 → quotient=0, remainder=7. Then 200 / 15 → quotient=13, remainder=5. Run these back-to-back, with start held during each DONE and no IDLE cycle between them.
- 100 / 0 → done in cycle 1, quotient=255, remainder=0, div_by_zero=1. A following 4 / 2 → quotient=2, remainder=0, div_by_zero=0.
- Start 180 / 7; in cycle 3 pulse start with 9 / 3 and change the inputs → the second request is ignored, and the result is quotient=25, remainder=5 in cycle 9.
- Start 250 / 11, then assert rst_n=0 asynchronously mid-cycle in cycle 4 → all outputs 0 immediately and state IDLE. After release, 250 / 11 → quotient=22, remainder=8.
- Exhaustive sweep of all 256×15 nonzero cases → quotient×divisor+remainder = dividend and remainder < divisor, checked against the multiplier model.

Source files
------------

// File: rtl/division_pkg.sv
// division_pkg: shared widths and FSM state codes
// for the sequential restoring divider.
package division_pkg;

    localparam int DIV_DW = 8;
    localparam int DIV_VW = 4;
    localparam int DIV_CW = $clog2(DIV_DW + 1);

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_CALC = 2'd1;
    localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/division_if.sv
// division_if: start/busy/done handshake and operand
// and result bus of the sequential divider.
interface division_if
    import division_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
);

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  quotient,
        input  remainder,
        input  busy,
        input  done,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output quotient,
        output remainder,
        output busy,
        output done,
        output div_by_zero
    );

endinterface

// File: rtl/division_step.sv
// division_step: one combinational restoring step,
// shift in a dividend bit and subtract if it fits.
module division_step
    import division_pkg::*;
#(
    parameter int VW = DIV_VW
) (
    input  logic [VW:0]   i_part,
    input  logic          i_bit,
    input  logic [VW-1:0] i_dvs,
    output logic [VW:0]   o_part,
    output logic          o_qbit
);

    logic [VW:0] w_trial;
    logic [VW:0] w_dvs;
    logic        w_ge;

    assign w_trial = {i_part[VW-1:0], i_bit};
    assign w_dvs   = {1'b0, i_dvs};
    // The top bit is always clear while a divide
    // runs; folding it in keeps the compare exact.
    assign w_ge    = i_part[VW] | (w_trial >= w_dvs);
    assign o_part  = w_ge ? (w_trial - w_dvs) : w_trial;
    assign o_qbit  = w_ge;

endmodule

// File: rtl/division_seq.sv
// division_seq: DW/VW unsigned restoring divider,
// one quotient bit per clock, start/busy/done.
module division_seq
    import division_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic       clk,
    input  logic       rst_n,
    division_if.slave  bus
);

    localparam int CW = $clog2(DW + 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_dvd;
    logic [VW-1:0] r_dvs;
    logic [VW:0]   r_part;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_rem;
    logic          r_busy;
    logic          r_done;
    logic          r_dbz;

    logic [VW:0]   w_next_part;
    logic          w_qbit;
    logic [DW:0]   w_cat;
    logic [DW-1:0] w_shift;
    logic          w_accept;
    logic          w_zero;
    logic          w_last;

    division_step #(
        .VW (VW)
    ) u_step (
        .i_part (r_part),
        .i_bit  (r_dvd[DW-1]),
        .i_dvs  (r_dvs),
        .o_part (w_next_part),
        .o_qbit (w_qbit)
    );

    // Dividend bits leave at the top while quotient
    // bits enter at the bottom of the same register.
    assign w_cat    = {r_dvd, w_qbit};
    assign w_shift  = w_cat[DW-1:0];
    assign w_accept = bus.start &&
                      (r_state == S_IDLE ||
                       r_state == S_DONE);
    assign w_zero   = (bus.divisor == '0);
    assign w_last   = (r_cnt == CW'(1));

    // FSM, step counter, working and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_part  <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                if (w_zero) begin
                    r_state <= S_DONE;
                    r_quot  <= '1;
                    r_rem   <= '0;
                    r_dbz   <= 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end else begin
                    r_state <= S_CALC;
                    r_dvd   <= bus.dividend;
                    r_dvs   <= bus.divisor;
                    r_part  <= '0;
                    r_cnt   <= CW'(DW);
                    r_dbz   <= 1'b0;
                    r_busy  <= 1'b1;
                end
            end else if (r_state == S_CALC) begin
                r_part <= w_next_part;
                r_dvd  <= w_shift;
                r_cnt  <= r_cnt - CW'(1);
                if (w_last) begin
                    r_state <= S_DONE;
                    r_quot  <= w_shift;
                    r_rem   <= w_next_part[VW-1:0];
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end else if (r_state == S_DONE) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_division_seq.sv
// tb_division_seq: scoreboard bench for division_seq,
// directed cases, exhaustive sweep, random ops.
module tb_division_seq;
    import division_pkg::*;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    division_if #(.DW(8), .VW(4)) bus();

    division_seq #(
        .DW (8),
        .VW (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    // Reference: plain integer division.
    function automatic exp_t model(input logic [7:0] a,
                                   input logic [3:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 4'd0) begin
            e.q = 8'hFF;
            e.r = 4'd0;
            e.z = 1'b1;
        end else begin
            e.q = 8'(int'(a) / int'(b));
            e.r = 4'(int'(a) % int'(b));
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Monitor: pop the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.busy && bus.done)
                chk("busy_done_overlap", 1, 0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", bus.quotient, e.q);
                    chk("remainder", bus.remainder, e.r);
                    chk("div_by_zero", bus.div_by_zero, e.z);
                    if (e.b != 4'd0) begin
                        chk("mul_identity",
                            int'(bus.quotient) * int'(e.b)
                            + int'(bus.remainder),
                            int'(e.a));
                        chk("rem_lt_div",
                            32'(bus.remainder < e.b), 1);
                    end
                end
            end
        end
    end

    // Issue one op from a negedge in IDLE or DONE;
    // returns at the negedge of the done cycle.
    task automatic do_op(input logic [7:0] a,
                         input logic [3:0] b,
                         input int pulse);
        int cyc;
        bit seen;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == pulse) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd9;
                bus.divisor  = 4'd3;
            end else if (cyc == pulse + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done)
                seen = 1'b1;
            else
                chk("busy", bus.busy,
                    32'(b != 4'd0 && cyc <= 8));
        end
        chk("latency", seen ? cyc : -1,
            (b == 4'd0) ? 1 : 9);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'd143, 4'd12, 0);
        @(negedge clk);

        do_op(8'd255, 4'd1, 0);
        do_op(8'd7, 4'd9, 0);
        do_op(8'd200, 4'd15, 0);
        @(negedge clk);

        do_op(8'd100, 4'd0, 0);
        @(negedge clk);
        do_op(8'd4, 4'd2, 0);
        repeat (3) @(negedge clk);
        chk("hold_quotient", bus.quotient, 2);
        chk("hold_remainder", bus.remainder, 0);
        chk("hold_busy", bus.busy, 0);

        do_op(8'd180, 4'd7, 3);
        @(negedge clk);

        bus.start    = 1'b1;
        bus.dividend = 8'd250;
        bus.divisor  = 4'd11;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("busy_pre_rst", bus.busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_quotient", bus.quotient, 0);
        chk("mid_rst_remainder", bus.remainder, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_dbz", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);
        do_op(8'd250, 4'd11, 0);
        @(negedge clk);

        for (int a = 0; a < 256; a++)
            for (int b = 1; b < 16; b++)
                do_op(8'(a), 4'(b), 0);
        @(negedge clk);

        for (int k = 0; k < 300; k++) begin
            do_op(8'($urandom), 4'($urandom), 0);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3))
                    @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
